dffram_bank: RTL and testbench

Parametrised single-port, byte-maskable flip-flop RAM bank with a request/grant front end and a response-valid back end. It replaces fixed 32-bit × 4K instruction/data memories in the SoC. It sits behind the TL-UL-to-SRAM adapter and serves both core instruction fetch and data memory. It adds configurable width and depth, an optional output register, read-before-write response data, and an optional post-reset clear sequencer.

---
 rtl/dffram_bank.sv | 168 ++++++++++++++++
 tb/tb_dffram_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dffram_bank.sv
// dffram_bank: single-port, byte-maskable flip-flop RAM bank.
// Request/grant front end, one response per granted request, read-before-write
// response data, optional second output register (OUT_REG).
// Define DFFRAM_CLEAR_EN to build the post-reset CLEAR/READY sequencer that
// zeroes the whole array before the first grant.
//
// state   | meaning
// S_CLEAR | writing zero to mem[ptr] each cycle, no grants, busy_o high
// S_READY | normal operation until the next reset
module dffram_bank #(
    parameter int    DW        = 32,
    parameter int    AW        = 12,
    parameter int    OUT_REG   = 0,
    parameter string INIT_FILE = ""
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            busy_o
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    logic          ready;
    logic          accept;
    logic          clear_we;
    logic [AW-1:0] clear_addr;

    logic          mem_we;
    logic [NB-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic          rv1_q, rv1_d;
    logic [DW-1:0] rd1_q, rd1_d;

`ifdef DFFRAM_CLEAR_EN
    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;

    // Sequencer next state: walk the pointer once over the array, then stay READY.
    // Exit is keyed on the last address rather than on pointer wrap.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_CLEAR) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
                state_d = S_READY;
            end
        end
        busy_d = (state_d == S_CLEAR);
    end

    // Sequencer state; every reset restarts the clear from address 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign ready      = (state_q == S_READY) && !RST;
    assign clear_we   = (state_q == S_CLEAR) && !RST;
    assign clear_addr = ptr_q;
    assign busy_o     = busy_q;
`else
    assign ready      = !RST;
    assign clear_we   = 1'b0;
    assign clear_addr = '0;
    assign busy_o     = 1'b0;
`endif

    assign gnt_o  = req_i & ready;
    assign accept = req_i & ready;

    // Single write port: the clear sequencer owns it while running, otherwise granted writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = addr_i;
        mem_wdata = wdata_i;
        if (clear_we) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = clear_addr;
            mem_wdata = '0;
        end else if (accept && we_i) begin
            mem_we = 1'b1;
            mem_be = be_i;
        end
    end

    // Array storage, byte-lane masked, never reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // First response stage: capture the old word on every accepted request.
    always_comb begin
        rv1_d = accept;
        rd1_d = accept ? mem[addr_i] : rd1_q;
    end

    // First response stage registers; reset drops any response in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rv1_q <= 1'b0;
            rd1_q <= '0;
        end else begin
            rv1_q <= rv1_d;
            rd1_q <= rd1_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic          rv2_q, rv2_d;
        logic [DW-1:0] rd2_q, rd2_d;

        // Output stage next value: data only moves with a valid response.
        always_comb begin
            rv2_d = rv1_q;
            rd2_d = rv1_q ? rd1_q : rd2_q;
        end

        // Output stage registers, adding one cycle of latency.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                rv2_q <= 1'b0;
                rd2_q <= '0;
            end else begin
                rv2_q <= rv2_d;
                rd2_q <= rd2_d;
            end
        end

        assign rvalid_o = rv2_q;
        assign rdata_o  = rd2_q;
    end else begin : g_no_out_reg
        assign rvalid_o = rv1_q;
        assign rdata_o  = rd1_q;
    end

endmodule

// File: tb/tb_dffram_bank.sv
// Bench for dffram_bank: instance a (AW=12, latency 1) and instance b
// (AW=4, latency 2) share one request stream; b sees the low 4 address bits.
module tb_dffram_bank;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

`ifdef DFFRAM_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic        CLK, RST, req, we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        a_gnt, a_rvalid, a_busy;
    logic [31:0] a_rdata;
    logic        b_gnt, b_rvalid, b_busy;
    logic [31:0] b_rdata;

    int   total = 0;
    int   bad   = 0;
    vec_t v[48];
    int   n = 0;

    dffram_bank #(.DW(32), .AW(12), .OUT_REG(0)) u_a (
        .CLK(CLK), .RST(RST), .req_i(req), .gnt_o(a_gnt), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
        .busy_o(a_busy)
    );

    dffram_bank #(.DW(32), .AW(4), .OUT_REG(1)) u_b (
        .CLK(CLK), .RST(RST), .req_i(req), .gnt_o(b_gnt), .we_i(we), .be_i(be),
        .addr_i(addr[3:0]), .wdata_i(wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
        .busy_o(b_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [3:0] b,
                       input logic [11:0] ad, input logic [31:0] wd,
                       input logic c, input logic [31:0] e);
        v[n].req   = r;
        v[n].we    = w;
        v[n].be    = b;
        v[n].addr  = ad;
        v[n].wdata = wd;
        v[n].chk   = c;
        v[n].exp   = e;
        n++;
    endtask

    task automatic chk_resp(input string nm, input logic rv, input logic [31:0] rd,
                            input vec_t x, inout logic hold_ok, inout logic [31:0] hold_val);
        chk({nm, "_rvalid"}, 32'(rv), 32'(x.req));
        if (x.req) begin
            if (x.chk) chk({nm, "_rdata"}, rd, x.exp);
            hold_ok  = x.chk;
            hold_val = x.exp;
        end else if (hold_ok) begin
            chk({nm, "_hold"}, rd, hold_val);
        end
    endtask

    initial begin
        int          cnt;
        logic        gnt_seen;
        logic        a_ok, b_ok;
        logic [31:0] a_last, b_last;

        // req, we, be, addr, wdata, check data, expected rdata
        add(1, 1, 4'hF, 12'h005, 32'hAABBCCDD, 0, 32'h0);
        add(1, 1, 4'hA, 12'h005, 32'h11223344, 1, 32'hAABBCCDD);
        add(1, 0, 4'h0, 12'h005, 32'h0,        1, 32'h11BB33DD);
        add(1, 1, 4'hF, 12'hFFF, 32'hDEADBEEF, 0, 32'h0);
        add(1, 0, 4'h0, 12'hFFF, 32'h0,        1, 32'hDEADBEEF);
        add(0, 0, 4'h0, 12'h000, 32'h0,        0, 32'h0);
        add(1, 1, 4'h0, 12'h005, 32'hFFFFFFFF, 1, 32'h11BB33DD);
        add(1, 0, 4'h0, 12'h005, 32'h0,        1, 32'h11BB33DD);
        add(1, 1, 4'h1, 12'hFFF, 32'h00000055, 1, 32'hDEADBEEF);
        add(1, 0, 4'h0, 12'hFFF, 32'h0,        1, 32'hDEADBE55);
        for (int i = 0; i < 16; i++) add(1, 1, 4'hF, 12'h100 + 12'(i), 32'hC0DE0000 + 32'(i), 0, 32'h0);
        for (int i = 0; i < 16; i++) add(1, 0, 4'h0, 12'h100 + 12'(i), 32'h0, 1, 32'hC0DE0000 + 32'(i));

        RST = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = 12'h0; wdata = 32'h0;
        @(negedge CLK); #1;
        chk("rst_a_rvalid", 32'(a_rvalid), 32'(0));
        chk("rst_a_rdata",  a_rdata, 32'h0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'(0));
        chk("rst_b_rdata",  b_rdata, 32'h0);
        chk("rst_a_gnt",    32'(a_gnt), 32'(0));
        chk("rst_b_gnt",    32'(b_gnt), 32'(0));
        chk("rst_a_busy",   32'(a_busy), 32'(BUSY_RST));
        chk("rst_b_busy",   32'(b_busy), 32'(BUSY_RST));
        @(negedge CLK);

`ifdef DFFRAM_CLEAR_EN
        RST = 1'b0;
        repeat (7) @(negedge CLK);
        chk("midclr_busy", 32'(b_busy), 32'(1));
        chk("midclr_gnt",  32'(b_gnt), 32'(0));
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        cnt = 0;
        gnt_seen = 1'b0;
        while (b_busy && cnt < 100) begin
            if (b_gnt) gnt_seen = 1'b1;
            @(negedge CLK);
            cnt++;
        end
        chk("clr_busy_cycles", 32'(cnt), 32'(16));
        chk("clr_gnt_low",     32'(gnt_seen), 32'(0));
        chk("clr_gnt_after",   32'(b_gnt), 32'(1));
        req = 1'b0;
        cnt = 0;
        while (a_busy && cnt < 5000) begin
            @(negedge CLK);
            cnt++;
        end
        chk("a_clear_done", 32'(a_busy), 32'(0));
        for (int i = 0; i < 16; i++) begin
            req = 1'b1; we = 1'b0; addr = 12'(i);
            @(negedge CLK);
            req = 1'b0;
            chk("clr_rd_a_rvalid", 32'(a_rvalid), 32'(1));
            chk("clr_rd_a_rdata",  a_rdata, 32'h0);
            @(negedge CLK);
            chk("clr_rd_b_rvalid", 32'(b_rvalid), 32'(1));
            chk("clr_rd_b_rdata",  b_rdata, 32'h0);
        end
`else
        req = 1'b0;
        RST = 1'b0;
`endif
        repeat (2) @(negedge CLK);

        a_ok = 1'b0; b_ok = 1'b0; a_last = 32'h0; b_last = 32'h0;
        for (int i = 0; i < n; i++) begin
            req = v[i].req; we = v[i].we; be = v[i].be; addr = v[i].addr; wdata = v[i].wdata;
            #1;
            chk("gnt_a", 32'(a_gnt), 32'(v[i].req));
            chk("gnt_b", 32'(b_gnt), 32'(v[i].req));
            @(negedge CLK);
            chk_resp("a", a_rvalid, a_rdata, v[i], a_ok, a_last);
            if (i > 0) chk_resp("b", b_rvalid, b_rdata, v[i-1], b_ok, b_last);
            else       chk("b_idle_rvalid", 32'(b_rvalid), 32'(0));
        end
        req = 1'b0; we = 1'b0; be = 4'h0;
        @(negedge CLK);
        chk_resp("b", b_rvalid, b_rdata, v[n-1], b_ok, b_last);
        chk("a_tail_rvalid", 32'(a_rvalid), 32'(0));

        req = 1'b1; we = 1'b0; addr = 12'h005;
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("rstresp_a_rvalid", 32'(a_rvalid), 32'(0));
        chk("rstresp_a_rdata",  a_rdata, 32'h0);
        chk("rstresp_b_rvalid", 32'(b_rvalid), 32'(0));
        chk("rstresp_b_rdata",  b_rdata, 32'h0);
        req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("rstresp_a_none", 32'(a_rvalid), 32'(0));
            chk("rstresp_b_none", 32'(b_rvalid), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
